// File: rtl/tap_player.sv
// TAP cassette player: buffers hps_io download bytes in a small FIFO and
// replays one byte per sample slot as a tape level derived from ce_1m.
module tap_player #(
   parameter int FIFO_AW    = 4,
   parameter int SAMPLE_DIV = 22,
   parameter int LEVEL_BIT  = 6
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ce_1m,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic        tape_out,
   output logic        playing,
   output logic [15:0] underrun_cnt,
   output logic [23:0] byte_cnt
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_C = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0] HALF_C = {2'b01, {(FIFO_AW-1){1'b0}}};
   localparam logic [7:0]       DIV_LAST = 8'(SAMPLE_DIV - 1);

   typedef enum logic [1:0] {IDLE, PREFILL, PLAY, DONE} state_t;

   state_t             state, state_nx;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic [7:0]         div;
   logic               dl_q;
   logic               dl_rise, full, empty, push, pop, slot;

   assign dl_rise = ioctl_download & ~dl_q;
   assign full    = (count == FULL_C);
   assign empty   = (count == '0);
   // The dl_rise cycle writes into the FIFO as it is being cleared, so the stale full flag must not block it.
   assign push    = ioctl_download & ioctl_wr & (dl_rise | ~full);
   assign slot    = (state == PLAY) & ce_1m & (div == DIV_LAST);
   assign pop     = slot & ~empty & ~dl_rise;

   assign ioctl_wait = full;
   assign playing    = (state == PREFILL) || (state == PLAY);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nx and no latch is inferred.
      state_nx = state;
      if (dl_rise) begin
         state_nx = PREFILL;
      end else begin
         unique case (state)
            PREFILL: begin
               if (count >= HALF_C)     state_nx = PLAY;
               else if (!ioctl_download) state_nx = empty ? DONE : PLAY;
            end
            PLAY:    if (slot && empty && !ioctl_download) state_nx = DONE;
            default: state_nx = state;
         endcase
      end
   end

   // NOTE: the byte store has no reset; count and pointers alone define which entries are valid.
   always_ff @(posedge clk_sys) begin
      if (push) mem[dl_rise ? '0 : wr_ptr] <= ioctl_dout;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dl_q         <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         div          <= '0;
         tape_out     <= 1'b0;
         underrun_cnt <= '0;
         byte_cnt     <= '0;
      end else begin
         dl_q <= ioctl_download;
         if (dl_rise) begin
            wr_ptr       <= {{(FIFO_AW-1){1'b0}}, push};
            rd_ptr       <= '0;
            count        <= {{FIFO_AW{1'b0}}, push};
            div          <= '0;
            tape_out     <= 1'b0;
            underrun_cnt <= '0;
            byte_cnt     <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
            if (state == PLAY && ce_1m) div <= (div == DIV_LAST) ? 8'd0 : div + 8'd1;
            if (pop) begin
               tape_out <= mem[rd_ptr][LEVEL_BIT];
               byte_cnt <= byte_cnt + 24'd1;
            end else if (slot) begin
               if (!ioctl_download)             tape_out     <= 1'b0;
               else if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tap_player.sv
// Directed bench for tap_player: a reference model queues expected tape levels
// as bytes are accepted and pops them at each modelled sample slot.
module tb_tap_player;

   localparam int SDIV  = 3;
   localparam int AW    = 4;
   localparam int DEPTH = 2 ** AW;
   localparam int LB    = 6;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ce_1m;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic        tape_out;
   logic        playing;
   logic [15:0] underrun_cnt;
   logic [23:0] byte_cnt;

   tap_player #(.FIFO_AW(AW), .SAMPLE_DIV(SDIV), .LEVEL_BIT(LB)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ce_1m(ce_1m),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
      .ioctl_wait(ioctl_wait), .tape_out(tape_out), .playing(playing),
      .underrun_cnt(underrun_cnt), .byte_cnt(byte_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   typedef enum {M_IDLE, M_PRE, M_PLAY, M_DONE} mstate_t;

   int          checks = 0;
   int          failures = 0;
   logic        exp_q[$];
   mstate_t     m_st = M_IDLE;
   int          m_div = 0;
   logic        m_dlq = 1'b0;
   logic        m_level = 1'b0;
   logic [15:0] m_under = '0;
   logic [23:0] m_bytes = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      check("tape_out", {31'b0, tape_out}, {31'b0, m_level});
      check("playing", {31'b0, playing}, {31'b0, (m_st == M_PRE || m_st == M_PLAY)});
      check("ioctl_wait", {31'b0, ioctl_wait}, {31'b0, (exp_q.size() == DEPTH)});
      check("underrun_cnt", {16'b0, underrun_cnt}, {16'b0, m_under});
      check("byte_cnt", {8'b0, byte_cnt}, {8'b0, m_bytes});
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_st = M_IDLE; m_div = 0; m_dlq = 1'b0; m_level = 1'b0; m_under = '0; m_bytes = '0;
   endtask

   // One clk_sys cycle with the given strobes; the model advances from pre-edge state.
   task automatic drive(input logic ce, input logic wr, input logic [7:0] d);
      logic dl, rise;
      int   sz;
      dl   = ioctl_download;
      rise = dl & ~m_dlq;
      sz   = exp_q.size();
      ce_1m = ce; ioctl_wr = wr; ioctl_dout = d;
      @(posedge clk_sys); #1;
      ce_1m = 1'b0; ioctl_wr = 1'b0; ioctl_dout = 8'h00;
      m_dlq = dl;
      if (rise) begin
         exp_q.delete();
         m_st = M_PRE; m_div = 0; m_level = 1'b0; m_under = '0; m_bytes = '0;
         if (wr) exp_q.push_back(d[LB]);
      end else begin
         case (m_st)
            M_PRE: begin
               if (sz >= DEPTH / 2) m_st = M_PLAY;
               else if (!dl)        m_st = (sz > 0) ? M_PLAY : M_DONE;
            end
            M_PLAY: if (ce) begin
               if (m_div == SDIV - 1) begin
                  m_div = 0;
                  if (sz > 0) begin
                     m_level = exp_q.pop_front();
                     m_bytes = m_bytes + 24'd1;
                  end else if (dl) begin
                     if (m_under != 16'hFFFF) m_under = m_under + 16'd1;
                  end else begin
                     m_st = M_DONE; m_level = 1'b0;
                  end
               end else begin
                  m_div++;
               end
            end
            default: ;
         endcase
         if (dl && wr && sz < DEPTH) exp_q.push_back(d[LB]);
      end
      chk_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 1'b0, 8'h00);
         drive(1'b0, 1'b0, 8'h00);
      end
   endtask

   initial begin
      reset_n = 1'b0; ce_1m = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_dout = 8'h00;

      // Reset state
      #12;
      check("rst_tape_out", {31'b0, tape_out}, 32'd0);
      check("rst_playing", {31'b0, playing}, 32'd0);
      check("rst_wait", {31'b0, ioctl_wait}, 32'd0);
      check("rst_byte_cnt", {8'b0, byte_cnt}, 32'd0);
      @(negedge clk_sys); reset_n = 1'b1;
      model_reset();
      drive(1'b0, 1'b0, 8'h00);

      // Four-byte download, levels 1,0,1,1, then DONE
      ioctl_download = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 8'h40);
      drive(1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b1, 8'h40);
      drive(1'b0, 1'b1, 8'h40);
      ioctl_download = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      ticks(5 * SDIV + 2);
      check("a_done_byte_cnt", {8'b0, byte_cnt}, 32'd4);
      check("a_done_playing", {31'b0, playing}, 32'd0);

      // Burst of 20 writes ignoring wait, then a write while full at a slot
      ioctl_download = 1'b1;
      for (int i = 0; i < 20; i++)
         drive(1'b0, 1'b1, (i % 3 == 1) ? 8'h00 : 8'h40);
      check("burst_wait", {31'b0, ioctl_wait}, 32'd1);
      for (int i = 0; i < SDIV; i++) begin
         drive(1'b1, 1'b1, 8'hBF);
         if (i < SDIV - 1) drive(1'b0, 1'b1, 8'hBF);
      end
      check("slot_wait_released", {31'b0, ioctl_wait}, 32'd0);
      ioctl_download = 1'b0;
      ticks(16 * SDIV + 2);
      check("burst_byte_cnt", {8'b0, byte_cnt}, 32'd16);

      // Underrun gap during PLAY, resume, then restart with bytes still buffered
      ioctl_download = 1'b1;
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? 8'h40 : 8'h00);
      drive(1'b0, 1'b1, 8'h40);
      ticks(9 * SDIV);
      ticks(4 * SDIV + 1);
      check("gap_underruns", {16'b0, underrun_cnt}, 32'd4);
      for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 8'h40);
      ticks(2 * SDIV);
      ioctl_download = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      ioctl_download = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      check("restart_underrun", {16'b0, underrun_cnt}, 32'd0);
      check("restart_wait", {31'b0, ioctl_wait}, 32'd0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'hBF);
      ioctl_download = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      ticks(4 * SDIV + 1);
      check("restart_byte_cnt", {8'b0, byte_cnt}, 32'd3);

      // Asynchronous reset mid-PLAY with a full FIFO and tape high
      ioctl_download = 1'b1;
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'h40);
      ticks(SDIV);
      drive(1'b0, 1'b1, 8'h40);
      #2;
      reset_n = 1'b0; ioctl_download = 1'b0;
      #1;
      check("async_tape_out", {31'b0, tape_out}, 32'd0);
      check("async_playing", {31'b0, playing}, 32'd0);
      check("async_wait", {31'b0, ioctl_wait}, 32'd0);
      check("async_byte_cnt", {8'b0, byte_cnt}, 32'd0);
      check("async_underrun", {16'b0, underrun_cnt}, 32'd0);
      @(posedge clk_sys);
      @(negedge clk_sys); reset_n = 1'b1;
      model_reset();
      drive(1'b0, 1'b0, 8'h00);
      ticks(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tap_player.md
Name: tap_player

Overview:
- Sits between hps_io's ioctl download stream and orao_hw's cassette/audio input.
- Buffers the bytes of a TAP file in a small FIFO and throttles the HPS with ioctl_wait.
- Replays the bytes as a cassette level waveform at a fixed sample rate derived from ce_1m.
- Each byte is one sample; the tape level is bit LEVEL_BIT of the byte.

Parameters:
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW bytes (16).
- SAMPLE_DIV, 22: number of ce_1m ticks per sample (about 45 kHz at 1 MHz); valid range 1..255.
- LEVEL_BIT, 6: bit of each TAP byte used as the tape level.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ce_1m  in  1  1 MHz clock-enable strobe, one clk_sys cycle wide.
- ioctl_download  in  1  TAP download active, from hps_io.
- ioctl_wr  in  1  byte-valid strobe, from hps_io.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  back-pressure to hps_io; 1 = FIFO full.
- tape_out  out  1  cassette level to orao_hw / audio mixer.
- playing  out  1  1 while in PREFILL or PLAY.
- underrun_cnt  out  16  saturating count of sample slots with an empty FIFO during a download.
- byte_cnt  out  24  bytes consumed since playback start; wraps at 2^24.

Behaviour:
- Reset (reset_n=0, asynchronous): FIFO empty, pointers 0, state IDLE, divider 0, all outputs 0.
- Download start:
  - dl_rise = ioctl_download & ~dl_q, where dl_q is ioctl_download registered in clk_sys.
  - dl_rise is detected in any state. It clears the FIFO, the divider, underrun_cnt and byte_cnt, and enters PREFILL.
  - The cycle carrying dl_rise also accepts a write, if present, into the freshly cleared FIFO.
- FIFO write:
  - Push when ioctl_download & ioctl_wr & ~full.
  - A write while full is dropped; hps_io must honour ioctl_wait.
  - ioctl_wait = full, combinational from the count register. It is 1 exactly when count == 2**FIFO_AW.
  - Count width is FIFO_AW+1.
- FIFO push and pop in the same cycle: count unchanged, both pointers advance, and the data ordering is preserved.
- States:
  - IDLE: tape_out=0, playing=0. On dl_rise go to PREFILL.
  - PREFILL: playing=1 and tape_out is held at 0. Go to PLAY when count >= 2**(FIFO_AW-1), or when ioctl_download falls with count > 0. If ioctl_download falls with count == 0, go to DONE.
  - PLAY: the divider advances on ce_1m only. When the divider equals SAMPLE_DIV-1 and ce_1m=1, the divider returns to 0 and a sample slot occurs. At a slot:
    - FIFO not empty: pop, tape_out <= popped_byte[LEVEL_BIT], byte_cnt += 1. The pop and tape_out update take effect in the same clk_sys edge.
    - FIFO empty and ioctl_download=1: underrun. tape_out holds, underrun_cnt += 1 (saturating at 0xFFFF), stay in PLAY.
    - FIFO empty and ioctl_download=0: go to DONE.
  - DONE: tape_out <= 0, playing <= 0 in the transition cycle. Stay until dl_rise.
- Sample period: exactly SAMPLE_DIV ce_1m ticks between consecutive slots. The first slot occurs SAMPLE_DIV ce_1m ticks after entering PLAY.
- Playback is not paused while the CPU's ce is gated by ioctl_download. The player runs on ce_1m, independent of the CPU.
- A new download arriving mid-PLAY (dl_rise) restarts cleanly. Old FIFO contents are discarded, with no residual samples.

Test Plan:
- Reset with reset_n=0 mid-PLAY, asynchronously between clock edges -> tape_out, playing, ioctl_wait and counters read 0 immediately; state IDLE after release.
- Download of 4 bytes (0x40,0x00,0x40,0x40) with SAMPLE_DIV=3 -> PLAY entered once download ends. tape_out sequence is 1,0,1,1, each held 3 ce_1m ticks. Then DONE, tape_out=0, byte_cnt=4.
- Burst 20 writes without honouring wait (FIFO_AW=4, no pops because ce_1m=0) -> ioctl_wait=1 after the 16th write; writes 17-20 dropped; playback yields exactly the first 16 bytes.
- Download with a 100-tick gap in ioctl_wr during PLAY, SAMPLE_DIV=22 -> underrun_cnt increments once per slot during the gap (4 or 5), tape_out holds its last level, playback resumes after new bytes arrive.
- Second dl_rise while 10 bytes are still buffered -> FIFO count 0 next cycle, byte_cnt and underrun_cnt cleared, state PREFILL; no old byte ever appears on tape_out.
- Same-cycle push and pop with count=16 (ioctl_wr while full at a slot) -> the write is dropped because full is checked before the pop. Count becomes 15 and ioctl_wait deasserts on the next cycle.
